// File: rtl/image_stride_pkg.sv
// rtl/image_stride_pkg.sv - stride-mode and FSM encodings for the stride/decimation stage
package image_stride_pkg;

  typedef enum logic [1:0] {
    STRIDE_1   = 2'd0,
    STRIDE_2   = 2'd1,
    STRIDE_4   = 2'd2,
    STRIDE_RSV = 2'd3
  } stride_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Reserved mode behaves as stride 1.
  function automatic logic [1:0] stride_mask(input logic [1:0] mode);
    case (stride_mode_e'(mode))
      STRIDE_2: stride_mask = 2'd1;
      STRIDE_4: stride_mask = 2'd3;
      default:  stride_mask = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/image_stride_fifo_sync.sv
// rtl/image_stride_fifo_sync.sv - synchronous first-word-fall-through FIFO with free-slot count
module image_stride_fifo_sync #(
  parameter int WIDTH     = 65,
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 empty,
  output logic                 full,
  output logic [ADDR_BITS:0]   free_count
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic                 wr_ok, rd_ok;

  assign empty      = (count_q == '0);
  assign full       = (count_q == (ADDR_BITS+1)'(DEPTH));
  assign free_count = (ADDR_BITS+1)'(DEPTH) - count_q;
  assign rd_data    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ok    = wr_en && !full;
    rd_ok    = rd_en && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/image_stride_gen.sv
// rtl/image_stride_gen.sv - row/col stride decimation of channel-grouped pixel beats into a FWFT FIFO
// Optional beat counters enabled by IMAGE_STRIDE_PERF_CNT_EN.
module image_stride_gen
  import image_stride_pkg::*;
#(
  parameter int COMPUTE_CHANNEL_OUT_NUM = 8,
  parameter int WIDTH_DATA              = 8,
  parameter int PICTURE_NUM             = 1,
  parameter int WIDTH_FEATURE_SIZE      = 11,
  parameter int WIDTH_CH_TIMES          = 8,
  parameter int FIFO_ADDR_BITS          = 10
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   Start,
  input  logic [1:0]                                             Stride_Mode,
  input  logic [WIDTH_FEATURE_SIZE-1:0]                          Row_Num_In,
  input  logic [WIDTH_FEATURE_SIZE-1:0]                          Col_Num_In,
  input  logic [WIDTH_CH_TIMES-1:0]                              Channel_Times,
  input  logic                                                   S_Valid,
  output logic                                                   S_Ready,
  input  logic [COMPUTE_CHANNEL_OUT_NUM*WIDTH_DATA*PICTURE_NUM-1:0] S_Data,
  output logic                                                   M_Valid,
  input  logic                                                   M_Ready,
  output logic [COMPUTE_CHANNEL_OUT_NUM*WIDTH_DATA*PICTURE_NUM-1:0] M_Data,
  output logic                                                   M_Last,
  output logic                                                   Stride_Complete,
  output logic                                                   Busy
`ifdef IMAGE_STRIDE_PERF_CNT_EN
  ,
  output logic [31:0]                                            In_Beat_Cnt,
  output logic [31:0]                                            Out_Beat_Cnt
`endif
);

  localparam int DW  = COMPUTE_CHANNEL_OUT_NUM * WIDTH_DATA * PICTURE_NUM;
  localparam int FW  = DW + 1;
  localparam int WFS = WIDTH_FEATURE_SIZE;
  localparam int WCT = WIDTH_CH_TIMES;

  state_e               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [WFS-1:0]       rows_q, rows_d, cols_q, cols_d;
  logic [WCT-1:0]       ct_q, ct_d;
  logic [WFS-1:0]       row_q, row_d, col_q, col_d;
  logic [WCT-1:0]       ch_q, ch_d;
  logic                 wr_valid_q, wr_valid_d;
  logic [FW-1:0]        wr_data_q, wr_data_d;
  logic                 done_q, done_d;

  logic [FW-1:0]        rd_data;
  logic                 fifo_empty, fifo_full;
  logic [FIFO_ADDR_BITS:0] free_count;

  logic                 accept, rd_en, dims_ok;
  logic                 ch_last, col_last, row_last, keep, last_tag;
  logic [WFS-1:0]       mask, rows_m1, cols_m1;
  logic [WCT-1:0]       ct_m1;

  // Two free slots: one for the beat in the write register, one for this beat.
  assign S_Ready = (state_q == ST_RUN) && !fifo_full &&
                   (free_count >= (FIFO_ADDR_BITS+1)'(2));
  assign accept          = S_Valid && S_Ready;
  assign M_Valid         = !fifo_empty;
  assign rd_en           = M_Valid && M_Ready;
  assign M_Data          = rd_data[DW-1:0];
  assign M_Last          = rd_data[DW] && M_Valid;
  assign Stride_Complete = done_q;
  assign Busy            = (state_q != ST_IDLE);

  always_comb begin
    mask     = WFS'(stride_mask(mode_q));
    rows_m1  = rows_q - 1'b1;
    cols_m1  = cols_q - 1'b1;
    ct_m1    = ct_q - 1'b1;
    ch_last  = (ch_q == ct_m1);
    col_last = (col_q == cols_m1);
    row_last = (row_q == rows_m1);
    keep     = ((row_q & mask) == '0) && ((col_q & mask) == '0);
    last_tag = ch_last && (col_q == (cols_m1 & ~mask)) && (row_q == (rows_m1 & ~mask));
    dims_ok  = (Row_Num_In != '0) && (Col_Num_In != '0) && (Channel_Times != '0);

    state_d    = state_q;
    mode_d     = mode_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    ct_d       = ct_q;
    row_d      = row_q;
    col_d      = col_q;
    ch_d       = ch_q;
    done_d     = 1'b0;
    wr_valid_d = accept && keep;
    wr_data_d  = (accept && keep) ? {last_tag, S_Data} : wr_data_q;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if (dims_ok) begin
            state_d = ST_RUN;
            mode_d  = Stride_Mode;
            rows_d  = Row_Num_In;
            cols_d  = Col_Num_In;
            ct_d    = Channel_Times;
            row_d   = '0;
            col_d   = '0;
            ch_d    = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (ch_last) begin
            ch_d = '0;
            if (col_last) begin
              col_d = '0;
              if (row_last) begin
                row_d   = '0;
                state_d = ST_DRAIN;
              end else begin
                row_d = row_q + 1'b1;
              end
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && !wr_valid_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= '0;
      rows_q     <= '0;
      cols_q     <= '0;
      ct_q       <= '0;
      row_q      <= '0;
      col_q      <= '0;
      ch_q       <= '0;
      wr_valid_q <= 1'b0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      ct_q       <= ct_d;
      row_q      <= row_d;
      col_q      <= col_d;
      ch_q       <= ch_d;
      wr_valid_q <= wr_valid_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
    end
  end

  image_stride_fifo_sync #(
    .WIDTH     (FW),
    .ADDR_BITS (FIFO_ADDR_BITS)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_valid_q),
    .wr_data    (wr_data_q),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .free_count (free_count)
  );

`ifdef IMAGE_STRIDE_PERF_CNT_EN
  logic [31:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;

  always_comb begin
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    if (state_q == ST_IDLE && Start) begin
      in_cnt_d  = '0;
      out_cnt_d = '0;
    end else begin
      if (accept && (in_cnt_q != '1)) in_cnt_d = in_cnt_q + 1'b1;
      if (rd_en && (out_cnt_q != '1)) out_cnt_d = out_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  assign In_Beat_Cnt  = in_cnt_q;
  assign Out_Beat_Cnt = out_cnt_q;
`endif

endmodule
